// File: rtl/w4823_cmem_ctrl_if.sv
// Bus bundle for the coefficient-memory load controller.
// Covers the config, stream, FIR-busy and CMEM write signals. The master side drives config and stream.
interface w4823_cmem_ctrl_if #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 17
);
  logic          cfg_start;
  logic [AW-1:0] cfg_base;
  logic [AW:0]   cfg_len;
  logic          cfg_abort;
  logic          fir_busy;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic [AW-1:0] caddr;
  logic [DW-1:0] cin;
  logic          cload;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    output cfg_start, cfg_base, cfg_len, cfg_abort, fir_busy, s_valid, s_data,
    input  s_ready, caddr, cin, cload, busy, done, err
  );

  modport slave (
    input  cfg_start, cfg_base, cfg_len, cfg_abort, fir_busy, s_valid, s_data,
    output s_ready, caddr, cin, cload, busy, done, err
  );
endinterface

// File: rtl/w4823_cmem_ctrl.sv
// Coefficient memory load controller.
// Streams a burst of words into CMEM at a wrapping address, and pauses while the FIR is reading.
module w4823_cmem_ctrl #(
  parameter int unsigned AW = 6,
  parameter int unsigned DW = 17
) (
  input logic               clk2,
  input logic               rst_n,
  w4823_cmem_ctrl_if.slave  bus
);
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [AW-1:0] caddr_q, caddr_d;
  logic [DW-1:0] cin_q, cin_d;
  logic          cload_q, cload_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          busy_q;
  logic          len_ok;
  logic          accept;

  // Abort takes priority over a word offered in the same cycle
  assign bus.s_ready = (state_q == LOAD) & ~bus.fir_busy & (rem_q != '0);
  assign accept      = bus.s_valid & bus.s_ready & ~bus.cfg_abort;
  assign len_ok      = (bus.cfg_len != '0) && (bus.cfg_len <= LW'(DEPTH));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    caddr_d = caddr_q;
    cin_d   = cin_q;
    cload_d = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.cfg_start) begin
          if (len_ok) begin
            state_d = LOAD;
            ptr_d   = bus.cfg_base;
            rem_d   = bus.cfg_len;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (bus.cfg_abort) begin
          state_d = IDLE;
          rem_d   = '0;
          err_d   = 1'b1;
        end else begin
          if (bus.cfg_start) err_d = 1'b1;
          // The address pointer wraps naturally at the top of CMEM
          if (accept) begin
            cload_d = 1'b1;
            caddr_d = ptr_q;
            cin_d   = bus.s_data;
            ptr_d   = ptr_q + AW'(1);
            rem_d   = rem_q - LW'(1);
            if (rem_q == LW'(1)) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A reset also discards any write being registered on the same edge
  always_ff @(posedge clk2) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      caddr_q <= '0;
      cin_q   <= '0;
      cload_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      caddr_q <= caddr_d;
      cin_q   <= cin_d;
      cload_q <= cload_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= (state_d == LOAD);
    end
  end

  assign bus.caddr = caddr_q;
  assign bus.cin   = cin_q;
  assign bus.cload = cload_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;
endmodule

// File: tb/tb_w4823_cmem_ctrl.sv
// Testbench for w4823_cmem_ctrl: directed scenarios and a random phase.
// A transaction-level reference model checks the outputs every cycle.
module tb_w4823_cmem_ctrl;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 17;

  logic clk2;
  logic rst_n;

  w4823_cmem_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  w4823_cmem_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk2  (clk2),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk2 = 1'b0;
    forever #5 clk2 = ~clk2;
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: whether a burst is open, where the next word goes, and how many words are left
  bit          m_active = 0;
  int          m_ptr    = 0;
  int          m_left   = 0;
  int          e_caddr  = 0;
  int          e_cin    = 0;
  bit          e_cload  = 0;
  bit          e_done   = 0;
  bit          e_err    = 0;

  int n_cload = 0;
  int n_done  = 0;
  int last_done_caddr = -1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready();
    return m_active && !bus.fir_busy && (m_left > 0);
  endfunction

  // One rising edge of the spec-level behaviour, driven from the bench's own stimulus
  task automatic model_step();
    int len;
    bit rdy;
    len = int'(bus.cfg_len);
    rdy = model_ready();
    e_cload = 0;
    e_done  = 0;
    if (!rst_n) begin
      m_active = 0; m_ptr = 0; m_left = 0;
      e_caddr = 0; e_cin = 0; e_err = 0;
    end else if (!m_active) begin
      if (bus.cfg_start) begin
        if (len >= 1 && len <= 64) begin
          m_active = 1; m_ptr = int'(bus.cfg_base); m_left = len; e_err = 0;
        end else begin
          e_err = 1;
        end
      end
    end else if (bus.cfg_abort) begin
      m_active = 0; m_left = 0; e_err = 1;
    end else begin
      if (bus.cfg_start) e_err = 1;
      if (bus.s_valid && rdy) begin
        e_cload = 1;
        e_caddr = m_ptr;
        e_cin   = int'(bus.s_data);
        m_ptr   = (m_ptr + 1) % 64;
        m_left  = m_left - 1;
        if (m_left == 0) begin
          m_active = 0;
          e_done   = 1;
        end
      end
    end
  endtask

  // One clock: check s_ready before the edge, then every registered output after it
  task automatic cyc();
    #1;
    chk("s_ready", 32'(bus.s_ready), 32'(model_ready()));
    @(posedge clk2);
    model_step();
    #1;
    chk("cload", 32'(bus.cload), 32'(e_cload));
    chk("done",  32'(bus.done),  32'(e_done));
    chk("busy",  32'(bus.busy),  32'(m_active));
    chk("err",   32'(bus.err),   32'(e_err));
    chk("caddr", 32'(bus.caddr), 32'(e_caddr));
    chk("cin",   32'(bus.cin),   32'(e_cin));
    if (bus.cload === 1'b1) n_cload++;
    if (bus.done === 1'b1) begin
      n_done++;
      last_done_caddr = int'(bus.caddr);
    end
  endtask

  task automatic clr_counts();
    n_cload = 0;
    n_done  = 0;
    last_done_caddr = -1;
  endtask

  task automatic idle_inputs();
    bus.cfg_start = 0; bus.cfg_abort = 0; bus.fir_busy = 0; bus.s_valid = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    cyc();
    cyc();
    rst_n = 1;
  endtask

  task automatic start_burst(int b, int l);
    bus.cfg_base  = AW'(b);
    bus.cfg_len   = 7'(l);
    bus.cfg_start = 1;
    bus.s_valid   = 0;
    cyc();
    bus.cfg_start = 0;
  endtask

  task automatic feed(int n);
    for (int i = 0; i < n; i++) begin
      bus.s_valid = 1;
      bus.s_data  = DW'($urandom);
      cyc();
    end
    bus.s_valid = 0;
  endtask

  task automatic full_load();
    clr_counts();
    start_burst(0, 64);
    feed(64);
    chk("full_cloads", 32'(n_cload), 32'd64);
    chk("full_dones",  32'(n_done),  32'd1);
    chk("full_last_caddr", 32'(last_done_caddr), 32'd63);
    cyc();
    chk("full_busy_after", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    bus.cfg_base = '0;
    bus.cfg_len  = '0;
    bus.s_data   = '0;
    @(posedge clk2);
    #1;
    do_reset();
    chk("rst_busy",  32'(bus.busy),  32'd0);
    chk("rst_err",   32'(bus.err),   32'd0);
    chk("rst_caddr", 32'(bus.caddr), 32'd0);

    full_load();

    // Burst that crosses the top of CMEM
    clr_counts();
    start_burst(60, 8);
    feed(8);
    chk("wrap_cloads", 32'(n_cload), 32'd8);
    chk("wrap_done_caddr", 32'(last_done_caddr), 32'd3);

    // FIR read stalls the stream mid-burst
    clr_counts();
    start_burst(20, 4);
    feed(2);
    chk("stall_pre", 32'(n_cload), 32'd2);
    bus.fir_busy = 1;
    bus.s_valid  = 1;
    for (int i = 0; i < 5; i++) begin
      bus.s_data = DW'($urandom);
      cyc();
    end
    chk("stall_mid", 32'(n_cload), 32'd2);
    bus.fir_busy = 0;
    feed(2);
    chk("stall_total", 32'(n_cload), 32'd4);
    chk("stall_dones", 32'(n_done),  32'd1);
    chk("stall_err",   32'(bus.err), 32'd0);

    // Illegal lengths leave the controller idle and flag an error
    clr_counts();
    start_burst(7, 0);
    start_burst(7, 65);
    cyc();
    chk("bad_err",    32'(bus.err),  32'd1);
    chk("bad_busy",   32'(bus.busy), 32'd0);
    chk("bad_cloads", 32'(n_cload),  32'd0);
    start_burst(5, 3);
    chk("legal_clears_err", 32'(bus.err), 32'd0);
    feed(3);

    // Start during a burst, then abort after three words
    clr_counts();
    start_burst(10, 10);
    feed(3);
    bus.cfg_base = AW'(40); bus.cfg_len = 7'(5); bus.cfg_start = 1;
    cyc();
    bus.cfg_start = 0;
    chk("restart_err",  32'(bus.err),  32'd1);
    chk("restart_busy", 32'(bus.busy), 32'd1);
    bus.cfg_abort = 1; bus.s_valid = 1;
    cyc();
    bus.cfg_abort = 0; bus.s_valid = 0;
    cyc();
    chk("abort_cloads", 32'(n_cload), 32'd3);
    chk("abort_dones",  32'(n_done),  32'd0);
    chk("abort_err",    32'(bus.err), 32'd1);

    // Abort and start together in LOAD: abort wins
    start_burst(0, 6);
    bus.cfg_abort = 1; bus.cfg_start = 1; bus.cfg_len = 7'(4);
    cyc();
    idle_inputs();
    chk("abort_start_busy", 32'(bus.busy), 32'd0);
    chk("abort_start_err",  32'(bus.err),  32'd1);

    // Reset in the middle of a burst
    clr_counts();
    start_burst(0, 20);
    feed(5);
    rst_n = 0; bus.s_valid = 1;
    cyc();
    rst_n = 1; bus.s_valid = 0;
    chk("midrst_cload", 32'(bus.cload), 32'd0);
    chk("midrst_busy",  32'(bus.busy),  32'd0);
    cyc();
    chk("midrst_cloads", 32'(n_cload), 32'd5);
    full_load();

    // Random phase
    for (int i = 0; i < 600; i++) begin
      rst_n         = ($urandom_range(0, 199) != 0);
      bus.cfg_start = ($urandom_range(0, 15) == 0);
      bus.cfg_base  = AW'($urandom);
      bus.cfg_len   = 7'($urandom_range(0, 70));
      bus.cfg_abort = ($urandom_range(0, 39) == 0);
      bus.fir_busy  = ($urandom_range(0, 3) == 0);
      bus.s_valid   = ($urandom_range(0, 1) == 1);
      bus.s_data    = DW'($urandom);
      cyc();
    end
    rst_n = 1;
    idle_inputs();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
